// File: rtl/mem_arbiter.sv
// Shares one RAM port among the per-core icache/dcache requesters of a multi-core MIPS.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin core selection; default is fixed priority.
module mem_arbiter #(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [WORD_W-1:0]      iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [WORD_W-1:0]      dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);
  localparam int unsigned CoreW = (CPUS > 1) ? $clog2(CPUS) : 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StServe = 1'b1;

  localparam logic [1:0] SrcI  = 2'd0;
  localparam logic [1:0] SrcDr = 2'd1;
  localparam logic [1:0] SrcDw = 2'd2;

  localparam logic [1:0] RamAccess = 2'd2;

  logic [0:0]       state_q, state_d;
  logic [CoreW-1:0] gcore_q, gcore_d;
  logic [1:0]       gsrc_q, gsrc_d;

  logic [CPUS-1:0]   core_req;
  logic [CoreW-1:0]  pick;
  logic [1:0]        src_pick;
  logic              any_req;
  logic              done;
  logic              win_req;
  logic [WORD_W-1:0] iaddr_a  [CPUS];
  logic [WORD_W-1:0] daddr_a  [CPUS];
  logic [WORD_W-1:0] dstore_a [CPUS];

  for (genvar c = 0; c < CPUS; c++) begin : g_unpack
    assign iaddr_a[c]  = iaddr[c*WORD_W +: WORD_W];
    assign daddr_a[c]  = daddr[c*WORD_W +: WORD_W];
    assign dstore_a[c] = dstore[c*WORD_W +: WORD_W];
  end

  assign core_req = iREN | dREN | dWEN;
  assign any_req  = |core_req;
  assign iload    = ramload;
  assign dload    = ramload;
  assign done     = (state_q == StServe) && (ramstate == RamAccess);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [CoreW-1:0] last_q, last_d;
  logic [CoreW-1:0] rr_idx;

  // Scan from farthest to nearest so the core right after last_q wins.
  always_comb begin
    pick   = '0;
    rr_idx = '0;
    for (int k = CPUS; k >= 1; k--) begin
      rr_idx = CoreW'((int'(last_q) + k) % CPUS);
      if (core_req[rr_idx]) begin
        pick = rr_idx;
      end
    end
  end

  assign last_d = done ? gcore_q : last_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q <= CoreW'(CPUS - 1);
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    pick = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      if (core_req[k]) begin
        pick = CoreW'(k);
      end
    end
  end
`endif

  always_comb begin
    src_pick = SrcI;
    if (dWEN[pick]) begin
      src_pick = SrcDw;
    end else if (dREN[pick]) begin
      src_pick = SrcDr;
    end
  end

  always_comb begin
    case (gsrc_q)
      SrcDw:   win_req = dWEN[gcore_q];
      SrcDr:   win_req = dREN[gcore_q];
      default: win_req = iREN[gcore_q];
    endcase
  end

  // A completed access takes precedence over a request dropped in the same cycle.
  always_comb begin
    state_d = state_q;
    gcore_d = gcore_q;
    gsrc_d  = gsrc_q;
    if (state_q == StIdle) begin
      if (any_req) begin
        state_d = StServe;
        gcore_d = pick;
        gsrc_d  = src_pick;
      end
    end else if (done || !win_req) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      gcore_q <= '0;
      gsrc_q  <= SrcI;
    end else begin
      state_q <= state_d;
      gcore_q <= gcore_d;
      gsrc_q  <= gsrc_d;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    if (state_q == StServe) begin
      if (gsrc_q == SrcDw) begin
        ramWEN   = 1'b1;
        ramaddr  = daddr_a[gcore_q];
        ramstore = dstore_a[gcore_q];
      end else begin
        ramREN  = 1'b1;
        ramaddr = (gsrc_q == SrcI) ? iaddr_a[gcore_q] : daddr_a[gcore_q];
      end
      if (done) begin
        if (gsrc_q == SrcI) begin
          iwait[gcore_q] = 1'b0;
        end else begin
          dwait[gcore_q] = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts every cycle's RAM bus
// and every acknowledge; a negedge monitor pops and compares. Honours MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
  localparam int CPUS = 2;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [1:0]  iw;
    logic [1:0]  dw;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  iREN = '0, dREN = '0, dWEN = '0;
  logic [63:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [1:0]  iwait, dwait;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [31:0] ramload = '0;
  logic        ramREN, ramWEN;
  logic [1:0]  ramstate = 2'd0;

  mem_arbiter #(.CPUS(2), .WORD_W(32)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  exp_t exp_bus[$];
  exp_t exp_ack[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   ack_cnt[CPUS];

  // Reference model: a transaction in flight (who, which source) plus the last served core.
  bit          m_busy = 0;
  int          m_core = 0;
  int          m_src  = 0;  // 0 icache read, 1 dcache read, 2 dcache write
  int          m_last = CPUS - 1;
  int          ack_core = -1;
  int          ack_src  = -1;
  logic [31:0] ia[CPUS], da[CPUS], ds[CPUS];

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endfunction

  function automatic bit wants(int c, int src);
    case (src)
      2:       return dWEN[c];
      1:       return dREN[c];
      default: return iREN[c];
    endcase
  endfunction

  task automatic cycle(input bit rst, input logic [1:0] ir, input logic [1:0] dr,
                       input logic [1:0] dw, input logic [1:0] st);
    exp_t e;
    int   order[$];
    @(posedge CLK);
    #1;
    RST = rst; iREN = ir; dREN = dr; dWEN = dw; ramstate = st; ramload = $urandom;
    iaddr = {ia[1], ia[0]}; daddr = {da[1], da[0]}; dstore = {ds[1], ds[0]};
    e = '{ren: 1'b0, wen: 1'b0, addr: '0, store: '0, iw: 2'b11, dw: 2'b11};
    ack_core = -1;
    ack_src  = -1;
    if (m_busy) begin
      if (m_src == 2) begin
        e.wen = 1'b1; e.addr = da[m_core]; e.store = ds[m_core];
      end else begin
        e.ren = 1'b1; e.addr = (m_src == 0) ? ia[m_core] : da[m_core];
      end
      if (st == 2'd2) begin
        if (m_src == 0) e.iw[m_core] = 1'b0;
        else e.dw[m_core] = 1'b0;
        exp_ack.push_back(e);
        ack_core = m_core;
        ack_src  = m_src;
      end
    end
    exp_bus.push_back(e);
    if (rst) begin
      m_busy = 0;
      m_last = CPUS - 1;
    end else if (!m_busy) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= CPUS; k++) order.push_back((m_last + k) % CPUS);
`else
      for (int k = 0; k < CPUS; k++) order.push_back(k);
`endif
      foreach (order[i]) begin
        if (!m_busy && (ir[order[i]] || dr[order[i]] || dw[order[i]])) begin
          m_busy = 1;
          m_core = order[i];
          m_src  = dw[m_core] ? 2 : (dr[m_core] ? 1 : 0);
        end
      end
    end else if (ack_core >= 0) begin
      m_busy = 0;
      m_last = m_core;
    end else if (!wants(m_core, m_src)) begin
      m_busy = 0;
    end
  endtask

  function automatic logic next_req(logic cur, bit acked);
    if (cur) return acked ? ($urandom_range(2) == 0) : ($urandom_range(29) != 0);
    return $urandom_range(3) == 0;
  endfunction

  always @(negedge CLK) begin
    exp_t e, a;
    if (exp_bus.size() > 0) begin
      e = exp_bus.pop_front();
      chk("bus", {58'd0, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait}, {58'd0, e});
      chk("load", {64'd0, iload, dload}, {64'd0, ramload, ramload});
      if (!(&{iwait, dwait})) begin
        for (int c = 0; c < CPUS; c++) if (!iwait[c] || !dwait[c]) ack_cnt[c]++;
        if (exp_ack.size() == 0) begin
          chk("unexpected_ack", {124'd0, iwait, dwait}, 128'hf);
        end else begin
          a = exp_ack.pop_front();
          chk("ack", {91'd0, iwait, dwait, ramaddr, ramWEN}, {91'd0, a.iw, a.dw, a.addr, a.wen});
        end
      end
    end
  end

  task automatic clear_counts();
    @(negedge CLK);
    #1;
    for (int c = 0; c < CPUS; c++) ack_cnt[c] = 0;
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    logic [1:0] ri, rd, rw, st;
    int         r;
    for (int c = 0; c < CPUS; c++) begin
      ia[c] = '0; da[c] = '0; ds[c] = '0; ack_cnt[c] = 0;
    end
    repeat (2) @(posedge CLK);
    cycle(0, 2'b00, 2'b00, 2'b00, 2'd0);  // reset state, nothing requested

    // Single icache read: three BUSY cycles, then ACCESS.
    ia[0] = 32'h40;
    cycle(0, 2'b01, 2'b00, 2'b00, 2'd0);
    repeat (3) cycle(0, 2'b01, 2'b00, 2'b00, 2'd1);
    cycle(0, 2'b01, 2'b00, 2'b00, 2'd2);
    cycle(0, 2'b00, 2'b00, 2'b00, 2'd0);

    // Same-core conflict: write, then read, then icache.
    da[0] = 32'h100; ds[0] = 32'hdead;
    cycle(0, 2'b01, 2'b01, 2'b01, 2'd0);
    cycle(0, 2'b01, 2'b01, 2'b01, 2'd2);
    cycle(0, 2'b01, 2'b01, 2'b00, 2'd0);
    cycle(0, 2'b01, 2'b01, 2'b00, 2'd2);
    cycle(0, 2'b01, 2'b00, 2'b00, 2'd0);
    cycle(0, 2'b01, 2'b00, 2'b00, 2'd2);
    cycle(0, 2'b00, 2'b00, 2'b00, 2'd0);

    // Both cores hold dREN, RAM answers at once: one transaction every two cycles.
    da[1] = 32'h200;
    clear_counts();
    repeat (16) cycle(0, 2'b00, 2'b11, 2'b00, 2'd2);
    cycle(0, 2'b00, 2'b00, 2'b00, 2'd0);
    settle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("rr_core0_acks", 128'(ack_cnt[0]), 128'd4);
    chk("rr_core1_acks", 128'(ack_cnt[1]), 128'd4);
`else
    chk("fixed_core0_acks", 128'(ack_cnt[0]), 128'd8);
    chk("fixed_core1_acks", 128'(ack_cnt[1]), 128'd0);
`endif

    // ERROR twice then ACCESS on core 1: exactly one ack.
    ia[1] = 32'h80;
    clear_counts();
    cycle(0, 2'b10, 2'b00, 2'b00, 2'd0);
    repeat (2) cycle(0, 2'b10, 2'b00, 2'b00, 2'd3);
    cycle(0, 2'b10, 2'b00, 2'b00, 2'd2);
    cycle(0, 2'b00, 2'b00, 2'b00, 2'd0);
    settle();
    chk("error_then_access_acks", 128'(ack_cnt[1]), 128'd1);

    // Abort core 0 mid-BUSY, then both request: last must still point past core 1.
    cycle(0, 2'b01, 2'b00, 2'b00, 2'd0);
    cycle(0, 2'b01, 2'b00, 2'b00, 2'd1);
    cycle(0, 2'b00, 2'b00, 2'b00, 2'd1);
    cycle(0, 2'b00, 2'b00, 2'b00, 2'd0);
    cycle(0, 2'b11, 2'b00, 2'b00, 2'd0);
    cycle(0, 2'b11, 2'b00, 2'b00, 2'd2);
    cycle(0, 2'b00, 2'b00, 2'b00, 2'd0);

    // Reset in the middle of a dcache write.
    ds[1] = 32'hbeef;
    cycle(0, 2'b00, 2'b00, 2'b10, 2'd0);
    cycle(0, 2'b00, 2'b00, 2'b10, 2'd1);
    cycle(1, 2'b00, 2'b00, 2'b10, 2'd1);
    cycle(0, 2'b00, 2'b00, 2'b10, 2'd2);
    cycle(0, 2'b00, 2'b00, 2'b10, 2'd2);
    cycle(0, 2'b00, 2'b00, 2'b00, 2'd0);

    // Randomised traffic.
    ri = '0; rd = '0; rw = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CPUS; c++) begin
        ri[c] = next_req(ri[c], ack_core == c && ack_src == 0);
        rd[c] = next_req(rd[c], ack_core == c && ack_src == 1);
        rw[c] = next_req(rw[c], ack_core == c && ack_src == 2);
        if ($urandom_range(7) == 0) ia[c] = $urandom;
        if ($urandom_range(7) == 0) da[c] = $urandom;
        if ($urandom_range(7) == 0) ds[c] = $urandom;
      end
      r  = $urandom_range(99);
      st = (r < 40) ? 2'd2 : (r < 70) ? 2'd1 : (r < 85) ? 2'd0 : 2'd3;
      cycle($urandom_range(299) == 0, ri, rd, rw, st);
    end

    repeat (4) cycle(0, 2'b00, 2'b00, 2'b00, 2'd0);
    settle();
    chk("acks_outstanding", 128'(exp_ack.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
